// File: rtl/sd_spi_master_if.sv
// Host I/O bus and SPI pins of the SD card slot, bundled for the SPI master.
// The host side (CPU/decoder and card model) is the master; the SPI block is the slave.
interface sd_spi_master_if;
  logic       CS;
  logic       A0;
  logic       WR;
  logic       RD;
  logic [7:0] DIN;
  logic [7:0] DOUT;
  logic       DOUT_EN;
  logic       SCK;
  logic       MOSI;
  logic       MISO;
  logic       SD_CS_N;

  modport master (
    output CS, A0, WR, RD, DIN, MISO,
    input  DOUT, DOUT_EN, SCK, MOSI, SD_CS_N
  );

  modport slave (
    input  CS, A0, WR, RD, DIN, MISO,
    output DOUT, DOUT_EN, SCK, MOSI, SD_CS_N
  );
endinterface

// File: rtl/sd_spi_master.sv
// Two-register CPU interface (DATA at 0x90, CTRL/STATUS at 0x91) driving one
// 8-bit SPI mode-0 transfer per DATA write, MSB first.
module sd_spi_master #(
  parameter int unsigned DIV_FAST = 2,
  parameter int unsigned DIV_SLOW = 64
) (
  input logic            CLK,
  input logic            RESET,
  sd_spi_master_if.slave bus
);

  localparam logic [7:0] DivFast = 8'(DIV_FAST);
  localparam logic [7:0] DivSlow = 8'(DIV_SLOW);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e     state_q, state_d;
  logic [1:0] cs_sync_q, wr_sync_q, rd_sync_q;
  logic       wr_act_q, rd_act_q;
  logic       sck_q, sck_d;
  logic [7:0] txsr_q, txsr_d;
  logic [7:0] rxsr_q, rxsr_d;
  logic [7:0] rxreg_q, rxreg_d;
  logic [7:0] div_q, div_d;
  logic [7:0] half_q, half_d;
  logic [3:0] bit_q, bit_d;
  logic       csel_q, csel_d;
  logic       slow_q, slow_d;
  logic       ovr_q, ovr_d;

  logic wr_act, rd_act, wr_ev, rd_ev, busy;

  // Strobe events fire once on the first synchronized cycle, however long the strobe.
  assign wr_act = cs_sync_q[1] & ~wr_sync_q[1];
  assign rd_act = cs_sync_q[1] & ~rd_sync_q[1];
  assign wr_ev  = wr_act & ~wr_act_q;
  assign rd_ev  = rd_act & ~rd_act_q & bus.A0;
  assign busy   = (state_q == StShift);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cs_sync_q <= 2'b00;
      wr_sync_q <= 2'b11;
      rd_sync_q <= 2'b11;
      wr_act_q  <= 1'b0;
      rd_act_q  <= 1'b0;
      state_q   <= StIdle;
      sck_q     <= 1'b0;
      txsr_q    <= 8'hFF;
      rxsr_q    <= 8'hFF;
      rxreg_q   <= 8'hFF;
      div_q     <= 8'd0;
      half_q    <= 8'd0;
      bit_q     <= 4'd0;
      csel_q    <= 1'b0;
      slow_q    <= 1'b1;
      ovr_q     <= 1'b0;
    end else begin
      cs_sync_q <= {cs_sync_q[0], bus.CS};
      wr_sync_q <= {wr_sync_q[0], bus.WR};
      rd_sync_q <= {rd_sync_q[0], bus.RD};
      wr_act_q  <= wr_act;
      rd_act_q  <= rd_act;
      state_q   <= state_d;
      sck_q     <= sck_d;
      txsr_q    <= txsr_d;
      rxsr_q    <= rxsr_d;
      rxreg_q   <= rxreg_d;
      div_q     <= div_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      csel_q    <= csel_d;
      slow_q    <= slow_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sck_d   = sck_q;
    txsr_d  = txsr_q;
    rxsr_d  = rxsr_q;
    rxreg_d = rxreg_q;
    div_d   = div_q;
    half_d  = half_q;
    bit_d   = bit_q;
    csel_d  = csel_q;
    slow_d  = slow_q;
    ovr_d   = ovr_q;

    // A read clears OVR, but an overrun in the same cycle sets it again below.
    if (rd_ev) begin
      ovr_d = 1'b0;
    end

    if (wr_ev) begin
      if (bus.A0) begin
        csel_d = bus.DIN[0];
        slow_d = bus.DIN[1];
      end else if (busy) begin
        ovr_d = 1'b1;
      end else begin
        txsr_d  = bus.DIN;
        div_d   = slow_q ? DivSlow : DivFast;
        half_d  = slow_q ? DivSlow : DivFast;
        bit_d   = 4'd0;
        sck_d   = 1'b0;
        state_d = StShift;
      end
    end

    unique case (state_q)
      StIdle: begin
      end
      StShift: begin
        if (half_q == 8'd1) begin
          half_d = div_q;
          sck_d  = ~sck_q;
          if (!sck_q) begin
            rxsr_d = {rxsr_q[6:0], bus.MISO};
            bit_d  = bit_q + 4'd1;
          end else begin
            txsr_d = {txsr_q[6:0], 1'b1};
            if (bit_q == 4'd8) begin
              rxreg_d = rxsr_q;
              bit_d   = 4'd0;
              half_d  = 8'd0;
              state_d = StIdle;
            end
          end
        end else begin
          half_d = half_q - 8'd1;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.SCK     = sck_q;
  assign bus.MOSI    = busy ? txsr_q[7] : 1'b1;
  assign bus.SD_CS_N = ~csel_q;
  assign bus.DOUT    = bus.A0 ? {busy, ovr_q, 4'b0000, slow_q, csel_q} : rxreg_q;
  assign bus.DOUT_EN = bus.CS & ~bus.RD;

endmodule

// File: tb/tb_sd_spi_master.sv
// Randomized bench for sd_spi_master: a scoreboard of expected SPI transfers and
// bus reads, checked by a monitor against a register/byte-level model.
module tb_sd_spi_master;
  localparam int unsigned DivFast = 2;
  localparam int unsigned DivSlow = 64;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  sd_spi_master_if bus();

  sd_spi_master #(.DIV_FAST(DivFast), .DIV_SLOW(DivSlow)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] tx;
    int         div;
    logic       csel;
    bit         chk_busy;
  } xfer_t;

  xfer_t      xfer_q[$];
  int         rd_q[$];
  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  int         exp_done = 0;
  int         rises = 0;
  logic [7:0] miso_pat = 8'hFF;
  logic       m_csel, m_slow, m_ovr;

  // Card model: presents the next pattern bit (MSB first) after each sampled rising edge.
  assign bus.MISO = (rises < 8) ? miso_pat[3'(7 - rises)] : 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int stat(input bit busy);
    return int'({busy, m_ovr, 4'b0000, m_slow, m_csel});
  endfunction

  // Monitor: pops expected read data on each bus read and expected transfers on each
  // completed 8-bit SCK burst.
  initial begin : monitor
    logic       prev_sck, prev_en, cs_and, cs_or;
    logic [7:0] mosi_b;
    int         cyc_n, falls, busy_cnt;
    int         rise_t[8];
    xfer_t      e;
    bit         ok;
    prev_sck = 1'b0; prev_en = 1'b0; cs_and = 1'b1; cs_or = 1'b0; mosi_b = 8'h00;
    cyc_n = 0; falls = 0; busy_cnt = 0;
    forever begin
      @(negedge CLK);
      cyc_n++;
      if (RESET) begin
        rises = 0; falls = 0; busy_cnt = 0; cs_and = 1'b1; cs_or = 1'b0;
        prev_sck = 1'b0; prev_en = bus.DOUT_EN;
      end else begin
        if (bus.DOUT_EN && !prev_en) begin
          if (rd_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_read: got 0x%0h expected none", bus.DOUT);
          end else begin
            chk(bus.A0 ? "read_status" : "read_data", int'(bus.DOUT), rd_q.pop_front());
          end
        end
        prev_en = bus.DOUT_EN;
        if (bus.DOUT_EN && bus.A0 && bus.DOUT[7]) busy_cnt++;
        if (!prev_sck && bus.SCK) begin
          if (rises < 8) rise_t[rises] = cyc_n;
          mosi_b = {mosi_b[6:0], bus.MOSI};
          rises++;
        end
        if (rises > 0) begin
          cs_and &= bus.SD_CS_N;
          cs_or  |= bus.SD_CS_N;
        end
        if (prev_sck && !bus.SCK) begin
          falls++;
          if (falls == 8) begin
            if (xfer_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL unexpected_transfer: got mosi 0x%0h expected none", mosi_b);
            end else begin
              e = xfer_q.pop_front();
              chk("mosi_byte", int'(mosi_b), int'(e.tx));
              ok = 1'b1;
              for (int k = 1; k < 8; k++) if (rise_t[k] - rise_t[k-1] != 2 * e.div) ok = 1'b0;
              if (cyc_n - rise_t[7] != e.div) ok = 1'b0;
              chk("sck_timing", int'(ok), 1);
              chk("sd_cs_n_steady", int'({cs_and, cs_or}), int'({~e.csel, ~e.csel}));
              if (e.chk_busy) chk("busy_len", busy_cnt, 16 * e.div);
            end
            done_cnt++;
            rises = 0; falls = 0; busy_cnt = 0; cs_and = 1'b1; cs_or = 1'b0;
          end
        end
        prev_sck = bus.SCK;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic bus_wr(input logic a0, input logic [7:0] d, input int hold);
    bus.CS = 1'b1; bus.A0 = a0; bus.DIN = d; bus.WR = 1'b0;
    cyc(hold);
    bus.WR = 1'b1;
    cyc(3);
    bus.CS = 1'b0;
    cyc(1);
  endtask

  task automatic ctrl_wr(input logic [7:0] d);
    bus_wr(1'b1, d, 1);
    m_csel = d[0];
    m_slow = d[1];
  endtask

  task automatic rd(input logic a0, input int exp);
    rd_q.push_back(exp);
    bus.CS = 1'b1; bus.A0 = a0; bus.RD = 1'b0;
    cyc(4);
    bus.RD = 1'b1; bus.CS = 1'b0;
    cyc(2);
    if (a0) m_ovr = 1'b0;
  endtask

  task automatic push_xfer(input logic [7:0] tx, input logic [7:0] pat, input bit cb);
    xfer_t e;
    e.tx = tx; e.div = m_slow ? DivSlow : DivFast; e.csel = m_csel; e.chk_busy = cb;
    xfer_q.push_back(e);
    exp_done++;
    miso_pat = pat;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt != exp_done && n < budget) begin
      cyc(1);
      n++;
    end
    if (done_cnt != exp_done) begin
      checks++; failures++;
      $display("FAIL transfer_timeout: got done=%0d expected %0d", done_cnt, exp_done);
      exp_done = done_cnt;
      xfer_q.delete();
    end
  endtask

  // DATA write, then hold a status read from the first busy cycle to completion.
  task automatic launch_watch(input logic [7:0] tx, input logic [7:0] pat);
    int d;
    d = m_slow ? DivSlow : DivFast;
    push_xfer(tx, pat, 1'b1);
    bus.CS = 1'b1; bus.A0 = 1'b0; bus.DIN = tx; bus.WR = 1'b0;
    cyc(1);
    bus.WR = 1'b1;
    cyc(2);
    rd_q.push_back(stat(1'b1));
    bus.A0 = 1'b1; bus.RD = 1'b0;
    wait_done(16 * d + 40);
    bus.RD = 1'b1; bus.CS = 1'b0;
    cyc(2);
    m_ovr = 1'b0;
  endtask

  initial begin : global_timeout
    #1_500_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] tx, pat, ctrl;
    int         r, n, d0;
    logic       p;
    bus.CS = 1'b0; bus.A0 = 1'b0; bus.WR = 1'b1; bus.RD = 1'b1; bus.DIN = 8'h00;
    m_csel = 1'b0; m_slow = 1'b1; m_ovr = 1'b0;
    cyc(3);
    chk("rst_sck", int'(bus.SCK), 0);
    chk("rst_mosi", int'(bus.MOSI), 1);
    chk("rst_sd_cs_n", int'(bus.SD_CS_N), 1);
    RESET = 1'b0;
    cyc(2);
    rd(1'b1, stat(1'b0));
    rd(1'b0, 8'hFF);

    // Fast transfer of 0xA5 against card pattern 0x3C.
    ctrl_wr(8'h01);
    launch_watch(8'hA5, 8'h3C);
    rd(1'b0, 8'h3C);
    rd(1'b1, stat(1'b0));

    // Slow byte; switching to fast mid-transfer only affects the following byte.
    ctrl_wr(8'h03);
    pat = 8'($urandom);
    push_xfer(8'hFF, pat, 1'b0);
    bus_wr(1'b0, 8'hFF, 1);
    cyc(100);
    ctrl_wr(8'h01);
    rd(1'b1, stat(1'b1));
    wait_done(16 * DivSlow + 200);
    rd(1'b0, pat);
    tx = 8'($urandom); pat = 8'($urandom);
    launch_watch(tx, pat);
    rd(1'b0, pat);

    // Overrun: second DATA write during a transfer is dropped and flags OVR once.
    ctrl_wr(8'h03);
    pat = 8'($urandom);
    push_xfer(8'h96, pat, 1'b0);
    bus_wr(1'b0, 8'h96, 1);
    cyc(20);
    bus_wr(1'b0, 8'h11, 1);
    m_ovr = 1'b1;
    rd(1'b1, stat(1'b1));
    rd(1'b1, stat(1'b1));
    wait_done(16 * DivSlow + 200);
    rd(1'b0, pat);
    rd(1'b1, stat(1'b0));

    // A long write strobe starts exactly one transfer.
    ctrl_wr(8'h01);
    tx = 8'($urandom); pat = 8'($urandom);
    push_xfer(tx, pat, 1'b0);
    bus_wr(1'b0, tx, 20);
    wait_done(200);
    d0 = done_cnt;
    cyc(100);
    chk("single_transfer", done_cnt, d0);
    chk("no_extra_sck", rises, 0);
    rd(1'b1, stat(1'b0));
    rd(1'b0, pat);

    // Reset at the 4th rising SCK edge aborts with no RXREG update.
    bus_wr(1'b0, 8'h5A, 1);
    r = 0; n = 0; p = bus.SCK;
    while (r < 4 && n < 200) begin
      @(negedge CLK);
      if (!p && bus.SCK) r++;
      p = bus.SCK;
      n++;
    end
    chk("reach_edge4", r, 4);
    RESET = 1'b1;
    #1;
    chk("abort_sck", int'(bus.SCK), 0);
    chk("abort_mosi", int'(bus.MOSI), 1);
    chk("abort_sd_cs_n", int'(bus.SD_CS_N), 1);
    cyc(3);
    RESET = 1'b0;
    m_csel = 1'b0; m_slow = 1'b1; m_ovr = 1'b0;
    n = 0;
    repeat (200) begin
      cyc(1);
      if (bus.SCK) n++;
    end
    chk("no_sck_after_reset", n, 0);
    rd(1'b0, 8'hFF);
    rd(1'b1, stat(1'b0));

    // Random bytes, card patterns, card select and speed.
    for (int i = 0; i < 8; i++) begin
      ctrl = {6'b000000, ($urandom_range(0, 3) == 0), 1'($urandom)};
      ctrl_wr(ctrl);
      tx = 8'($urandom); pat = 8'($urandom);
      launch_watch(tx, pat);
      rd(1'b0, pat);
      rd(1'b1, stat(1'b0));
    end

    cyc(5);
    chk("xfer_queue_drained", xfer_q.size(), 0);
    chk("read_queue_drained", rd_q.size(), 0);
    chk("transfer_count", done_cnt, exp_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
